// File: rtl/regfile_wb_ctrl.sv
`timescale 1ns/1ps
// Write-back port owner for an 8x8 register file: round-robin ALU/MEM arbiter plus RAW/WAW scoreboard.
// Accept in N -> rf_en in N+1, pending clears end of N+1; at most one wb ready per cycle, issue stalls while a source/dest is pending.
module regfile_wb_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [ADDR_W-1:0]          issue_rs1,
    input  logic [ADDR_W-1:0]          issue_rs2,
    input  logic [ADDR_W-1:0]          issue_rd,
    input  logic                       issue_has_rd,
    input  logic                       alu_wb_valid,
    output logic                       alu_wb_ready,
    input  logic [ADDR_W-1:0]          alu_wb_addr,
    input  logic [DATA_W-1:0]          alu_wb_data,
    input  logic                       mem_wb_valid,
    output logic                       mem_wb_ready,
    input  logic [ADDR_W-1:0]          mem_wb_addr,
    input  logic [DATA_W-1:0]          mem_wb_data,
    output logic                       rf_en,
    output logic [ADDR_W-1:0]          rf_write_addr,
    output logic [DATA_W-1:0]          rf_write_data,
    output logic [(1<<ADDR_W)-1:0]     pending,
    output logic                       err,
    output logic                       idle
);
    localparam int NREGS = 1 << ADDR_W;

    typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_t;

    src_t              last_grant;
    logic [NREGS-1:0]  pend_q;
    logic [NREGS-1:0]  pend_d;
    logic              en_q;
    logic              clr_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              err_q;
    logic              grant_alu;
    logic              grant_mem;
    logic              accept;
    logic              fire;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;

    always_comb begin
        grant_alu   = 1'b0;
        grant_mem   = 1'b0;
        acc_addr    = alu_wb_addr;
        acc_data    = alu_wb_data;
        issue_ready = !pend_q[issue_rs1] && !pend_q[issue_rs2] &&
                      !(issue_has_rd && pend_q[issue_rd]);
        fire        = issue_valid && issue_ready;
        // Nothing is accepted during reset: it would be discarded anyway.
        if (!rst) begin
            grant_alu = alu_wb_valid && (!mem_wb_valid || last_grant == SRC_MEM);
            grant_mem = mem_wb_valid && !grant_alu;
        end
        if (grant_mem) begin
            acc_addr = mem_wb_addr;
            acc_data = mem_wb_data;
        end
        accept = grant_alu || grant_mem;

        pend_d = pend_q;
        // A commit that was never scoreboarded must not clear a bit set by a later issue.
        if (en_q && clr_q) pend_d[wr_addr_q] = 1'b0;
        if (fire && issue_has_rd) pend_d[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= '0;
            en_q       <= 1'b0;
            clr_q      <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            err_q      <= 1'b0;
            last_grant <= SRC_MEM;
        end else begin
            pend_q <= pend_d;
            en_q   <= accept;
            if (accept) begin
                wr_addr_q  <= acc_addr;
                wr_data_q  <= acc_data;
                clr_q      <= pend_q[acc_addr];
                last_grant <= grant_mem ? SRC_MEM : SRC_ALU;
                if (!pend_q[acc_addr]) err_q <= 1'b1;
            end
        end
    end

    assign alu_wb_ready  = grant_alu;
    assign mem_wb_ready  = grant_mem;
    assign rf_en         = en_q && !rst;
    assign rf_write_addr = wr_addr_q;
    assign rf_write_data = wr_data_q;
    assign pending       = pend_q;
    assign err           = err_q;
    assign idle          = (pend_q == '0) && !rf_en;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
`timescale 1ns/1ps
// Directed vector table for the hazard/arbitration scenarios, then randomized traffic against a queue-based model.
module tb_regfile_wb_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid, issue_ready, issue_has_rd;
    logic [2:0] issue_rs1, issue_rs2, issue_rd;
    logic       alu_wb_valid, alu_wb_ready, mem_wb_valid, mem_wb_ready;
    logic [2:0] alu_wb_addr, mem_wb_addr;
    logic [7:0] alu_wb_data, mem_wb_data;
    logic       rf_en, err, idle;
    logic [2:0] rf_write_addr;
    logic [7:0] rf_write_data;
    logic [7:0] pending;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_wb_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
        .issue_has_rd(issue_has_rd),
        .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready),
        .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data),
        .mem_wb_valid(mem_wb_valid), .mem_wb_ready(mem_wb_ready),
        .mem_wb_addr(mem_wb_addr), .mem_wb_data(mem_wb_data),
        .rf_en(rf_en), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
        .pending(pending), .err(err), .idle(idle)
    );

    // Register file driven by the DUT's write port.
    logic [7:0] tb_rf [8] = '{default: 8'h00};
    always @(posedge clk) if (rf_en === 1'b1) tb_rf[rf_write_addr] <= rf_write_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       r, iv;
        logic [2:0] rs1, rs2, rd;
        logic       hrd, av;
        logic [2:0] aa;
        logic [7:0] ad;
        logic       mv;
        logic [2:0] ma;
        logic [7:0] md;
        logic       e_ir, e_ar, e_mr, e_en;
        logic [2:0] e_wa;
        logic [7:0] e_wd, e_p;
        logic       e_err, e_idle;
    } vec_t;

    function automatic vec_t mk(input logic r, iv, input logic [2:0] rs1, rs2, rd,
                                input logic hrd, av, input logic [2:0] aa, input logic [7:0] ad,
                                input logic mv, input logic [2:0] ma, input logic [7:0] md,
                                input logic e_ir, e_ar, e_mr, e_en, input logic [2:0] e_wa,
                                input logic [7:0] e_wd, e_p, input logic e_err, e_idle);
        vec_t v;
        v.r = r; v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.hrd = hrd;
        v.av = av; v.aa = aa; v.ad = ad; v.mv = mv; v.ma = ma; v.md = md;
        v.e_ir = e_ir; v.e_ar = e_ar; v.e_mr = e_mr; v.e_en = e_en;
        v.e_wa = e_wa; v.e_wd = e_wd; v.e_p = e_p; v.e_err = e_err; v.e_idle = e_idle;
        return v;
    endfunction

    task automatic drive(input logic r, iv, input logic [2:0] rs1, rs2, rd, input logic hrd,
                         input logic av, input logic [2:0] aa, input logic [7:0] ad,
                         input logic mv, input logic [2:0] ma, input logic [7:0] md);
        rst = r; issue_valid = iv; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd;
        issue_has_rd = hrd; alu_wb_valid = av; alu_wb_addr = aa; alu_wb_data = ad;
        mem_wb_valid = mv; mem_wb_addr = ma; mem_wb_data = md;
    endtask

    // Reference model state
    typedef struct { logic [2:0] a; logic [7:0] d; bit legit; } wr_t;
    wr_t        inflight[$];
    bit [7:0]   mp;
    bit         m_last_mem, m_err;
    logic [2:0] m_wa;
    logic [7:0] m_wd;

    function automatic logic [2:0] pick();
        logic [2:0] cand[$];
        for (int k = 0; k < 8; k++) if (mp[k]) cand.push_back(3'(k));
        if (cand.size() > 0 && $urandom_range(0, 7) != 0)
            return cand[$urandom_range(0, cand.size() - 1)];
        return 3'($urandom_range(0, 7));
    endfunction

    vec_t tbl[24];

    initial begin
        logic       r, iv, hrd, av, mv, e_ir, e_en, legit, take_alu, take_mem;
        logic [2:0] rs1, rs2, rd, aa, ma, acc_a;
        logic [7:0] ad, md, acc_d;

        //             r iv rs1 rs2 rd hrd  av aa ad     mv ma md      ir ar mr en wa wd     pend   err idle
        tbl[0]  = mk(1, 0, 0, 0, 0, 0,  0, 0, 8'h00,  0, 0, 8'h00,  1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1);
        tbl[1]  = mk(0, 1, 0, 0, 3, 1,  0, 0, 8'h00,  0, 0, 8'h00,  1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1);
        tbl[2]  = mk(0, 1, 3, 0, 0, 0,  1, 3, 8'h5A,  0, 0, 8'h00,  0, 1, 0, 0, 0, 8'h00, 8'h08, 0, 0);
        tbl[3]  = mk(0, 1, 3, 0, 0, 0,  0, 0, 8'h00,  0, 0, 8'h00,  0, 0, 0, 1, 3, 8'h5A, 8'h08, 0, 0);
        tbl[4]  = mk(0, 1, 3, 0, 0, 0,  0, 0, 8'h00,  0, 0, 8'h00,  1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1);
        tbl[5]  = mk(1, 0, 0, 0, 0, 0,  0, 0, 8'h00,  0, 0, 8'h00,  1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1);
        tbl[6]  = mk(0, 1, 0, 0, 1, 1,  0, 0, 8'h00,  0, 0, 8'h00,  1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1);
        tbl[7]  = mk(0, 1, 0, 0, 2, 1,  0, 0, 8'h00,  0, 0, 8'h00,  1, 0, 0, 0, 0, 8'h00, 8'h02, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0,  1, 1, 8'h11,  1, 2, 8'h22,  1, 1, 0, 0, 0, 8'h00, 8'h06, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 8'h00,  1, 2, 8'h22,  1, 0, 1, 1, 1, 8'h11, 8'h06, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 0,  0, 0, 8'h00,  0, 0, 8'h00,  1, 0, 0, 1, 2, 8'h22, 8'h04, 0, 0);
        tbl[11] = mk(0, 1, 0, 0, 1, 1,  0, 0, 8'h00,  0, 0, 8'h00,  1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1);
        tbl[12] = mk(0, 1, 0, 0, 2, 1,  0, 0, 8'h00,  0, 0, 8'h00,  1, 0, 0, 0, 0, 8'h00, 8'h02, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 0,  1, 1, 8'h33,  1, 2, 8'h44,  1, 1, 0, 0, 0, 8'h00, 8'h06, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0,  0, 0, 8'h00,  1, 2, 8'h44,  1, 0, 1, 1, 1, 8'h33, 8'h06, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0,  0, 0, 8'h00,  0, 0, 8'h00,  1, 0, 0, 1, 2, 8'h44, 8'h04, 0, 0);
        tbl[16] = mk(0, 1, 0, 0, 4, 1,  0, 0, 8'h00,  0, 0, 8'h00,  1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1);
        tbl[17] = mk(0, 1, 0, 0, 4, 1,  0, 0, 8'h00,  0, 0, 8'h00,  0, 0, 0, 0, 0, 8'h00, 8'h10, 0, 0);
        tbl[18] = mk(0, 1, 0, 1, 4, 0,  0, 0, 8'h00,  0, 0, 8'h00,  1, 0, 0, 0, 0, 8'h00, 8'h10, 0, 0);
        tbl[19] = mk(0, 0, 0, 0, 0, 0,  1, 4, 8'h77,  0, 0, 8'h00,  1, 1, 0, 0, 0, 8'h00, 8'h10, 0, 0);
        tbl[20] = mk(0, 0, 0, 0, 0, 0,  0, 0, 8'h00,  0, 0, 8'h00,  1, 0, 0, 1, 4, 8'h77, 8'h10, 0, 0);
        tbl[21] = mk(0, 0, 0, 0, 0, 0,  0, 0, 8'h00,  1, 5, 8'hA5,  1, 0, 1, 0, 0, 8'h00, 8'h00, 0, 1);
        tbl[22] = mk(0, 0, 0, 0, 0, 0,  0, 0, 8'h00,  0, 0, 8'h00,  1, 0, 0, 1, 5, 8'hA5, 8'h00, 1, 0);
        tbl[23] = mk(0, 0, 0, 0, 0, 0,  0, 0, 8'h00,  0, 0, 8'h00,  1, 0, 0, 0, 0, 8'h00, 8'h00, 1, 1);

        drive(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00);
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].iv, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].hrd,
                  tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].mv, tbl[i].ma, tbl[i].md);
            @(negedge clk);
            chk($sformatf("v%0d issue_ready", i), 32'(issue_ready), 32'(tbl[i].e_ir));
            chk($sformatf("v%0d alu_wb_ready", i), 32'(alu_wb_ready), 32'(tbl[i].e_ar));
            chk($sformatf("v%0d mem_wb_ready", i), 32'(mem_wb_ready), 32'(tbl[i].e_mr));
            chk($sformatf("v%0d rf_en", i), 32'(rf_en), 32'(tbl[i].e_en));
            if (tbl[i].e_en) begin
                chk($sformatf("v%0d rf_write_addr", i), 32'(rf_write_addr), 32'(tbl[i].e_wa));
                chk($sformatf("v%0d rf_write_data", i), 32'(rf_write_data), 32'(tbl[i].e_wd));
            end
            chk($sformatf("v%0d pending", i), 32'(pending), 32'(tbl[i].e_p));
            chk($sformatf("v%0d err", i), 32'(err), 32'(tbl[i].e_err));
            chk($sformatf("v%0d idle", i), 32'(idle), 32'(tbl[i].e_idle));
            @(posedge clk); #1;
        end
        chk("rf r1 after contention", 32'(tb_rf[1]), 32'h33);
        chk("rf r4 after waw", 32'(tb_rf[4]), 32'h77);
        chk("rf r5 after err write", 32'(tb_rf[5]), 32'hA5);

        // err stays set through idle cycles
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("err sticky c%0d", c), 32'(err), 32'h1);
            @(posedge clk); #1;
        end

        // reset lands while an accepted write is awaiting commit
        drive(0, 0, 0, 0, 0, 0, 1, 2, 8'hC3, 0, 0, 8'h00);
        @(negedge clk);
        chk("midrst alu accept", 32'(alu_wb_ready), 32'h1);
        @(posedge clk); #1;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00);
        @(negedge clk);
        chk("midrst rf_en during rst", 32'(rf_en), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst rf_en after", 32'(rf_en), 32'h0);
        chk("midrst pending", 32'(pending), 32'h0);
        chk("midrst err cleared", 32'(err), 32'h0);
        chk("midrst r2 unchanged", 32'(tb_rf[2]), 32'h44);
        @(posedge clk); #1;

        // randomized traffic from reset
        drive(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        mp = '0; m_last_mem = 1'b1; m_err = 1'b0; m_wa = '0; m_wd = '0;
        inflight.delete();
        av = 1'b0; mv = 1'b0; aa = '0; ma = '0; ad = '0; md = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r   = ($urandom_range(0, 199) == 0);
            iv  = 1'($urandom_range(0, 1));
            rs1 = 3'($urandom_range(0, 7));
            rs2 = 3'($urandom_range(0, 7));
            rd  = 3'($urandom_range(0, 7));
            hrd = ($urandom_range(0, 3) != 0);
            if (!av && $urandom_range(0, 1) == 1) begin
                av = 1'b1; aa = pick(); ad = 8'($urandom);
            end
            if (!mv && $urandom_range(0, 2) == 0) begin
                mv = 1'b1; ma = pick(); md = 8'($urandom);
            end
            drive(r, iv, rs1, rs2, rd, hrd, av, aa, ad, mv, ma, md);

            e_ir = !(mp[rs1] || mp[rs2] || (hrd && mp[rd]));
            take_alu = 1'b0;
            take_mem = 1'b0;
            if (!r) begin
                if (av && mv) begin
                    if (m_last_mem) take_alu = 1'b1;
                    else            take_mem = 1'b1;
                end else begin
                    take_alu = av;
                    take_mem = mv;
                end
            end
            e_en = !r && (inflight.size() > 0);

            @(negedge clk);
            chk("rnd issue_ready", 32'(issue_ready), 32'(e_ir));
            chk("rnd alu_wb_ready", 32'(alu_wb_ready), 32'(take_alu));
            chk("rnd mem_wb_ready", 32'(mem_wb_ready), 32'(take_mem));
            chk("rnd rf_en", 32'(rf_en), 32'(e_en));
            if (e_en) begin
                chk("rnd rf_write_addr", 32'(rf_write_addr), 32'(m_wa));
                chk("rnd rf_write_data", 32'(rf_write_data), 32'(m_wd));
            end
            chk("rnd pending", 32'(pending), 32'(mp));
            chk("rnd err", 32'(err), 32'(m_err));
            chk("rnd idle", 32'(idle), 32'(mp == 8'h00 && !e_en));

            if (r) begin
                mp = '0; m_last_mem = 1'b1; m_err = 1'b0; m_wa = '0; m_wd = '0;
                inflight.delete();
            end else begin
                acc_a = take_mem ? ma : aa;
                acc_d = take_mem ? md : ad;
                legit = mp[acc_a];
                if (inflight.size() > 0) begin
                    wr_t c;
                    c = inflight.pop_front();
                    if (c.legit) mp[c.a] = 1'b0;
                end
                if (iv && e_ir && hrd) mp[rd] = 1'b1;
                if (take_alu || take_mem) begin
                    inflight.push_back('{a: acc_a, d: acc_d, legit: legit});
                    if (!legit) m_err = 1'b1;
                    m_last_mem = take_mem;
                    m_wa = acc_a;
                    m_wd = acc_d;
                end
                if (take_alu) av = 1'b0;
                if (take_mem) mv = 1'b0;
            end
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
